// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- port bundle for the scoreboarded register file.
//   master : ID/WB side; drives read addresses, issue reservations,
//            cancels and the write-back port.
//   slave  : register file; returns read data, busy flags, issue_ready.
interface regfile_sb_if;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy1;
  logic        busy2;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_waddr;
  logic        issue_ready;
  logic        cancel_we;
  logic [4:0]  cancel_waddr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output raddr1, raddr2, issue_valid, issue_we, issue_waddr,
           cancel_we, cancel_waddr, rf_we, rf_waddr, rf_wdata,
    input  rdata1, rdata2, busy1, busy2, issue_ready
  );

  modport slave (
    input  raddr1, raddr2, issue_valid, issue_we, issue_waddr,
           cancel_we, cancel_waddr, rf_we, rf_waddr, rf_wdata,
    output rdata1, rdata2, busy1, busy2, issue_ready
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- 31 x 32-bit register file (x1..x31, x0 hardwired to 0)
// with a per-register in-flight write scoreboard.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : regfile_sb_if.slave
//     raddr1/2 -> rdata1/2 (combinational), busy1/2 (pending writer)
//     issue_valid/issue_we/issue_waddr -> issue_ready (reserve destination)
//     cancel_we/cancel_waddr : squashed writer releases its reservation
//     rf_we/rf_waddr/rf_wdata : write-back, commits data and releases
// Parameter CNT_W : width of each in-flight counter (saturates at all-ones).
// Optional macro REGFILE_BYPASS_EN : same-cycle write-through of rf_wdata to
// the read ports, and busy suppressed when the only pending writer is the
// write-back happening this cycle.
module regfile_sb #(
  parameter int CNT_W = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [CNT_W+1:0] ONE     = 1;

  logic [31:0]      regs [1:31];
  logic [CNT_W-1:0] cnt  [1:31];

  logic [31:1]      inc_hit;
  logic [31:1]      wb_hit;
  logic [31:1]      cn_hit;
  logic [CNT_W-1:0] cnt_iw;
  logic [CNT_W-1:0] cnt_r1;
  logic [CNT_W-1:0] cnt_r2;
  logic             issue_fire;

  // Net counter update: one increment and up to two releases in one cycle.
  // Each release only applies to a nonzero counter, and the combined result
  // floors at zero (WB + cancel against a count of 1 yields 0).
  function automatic logic [CNT_W-1:0] cnt_sat(input logic [CNT_W-1:0] c,
                                               input logic inc,
                                               input logic dec_wb,
                                               input logic dec_cn);
    logic signed [CNT_W+1:0] s;
    s = $signed({2'b00, c});
    if (inc)                  s = s + ONE;
    if (dec_wb && c != '0)    s = s - ONE;
    if (dec_cn && c != '0)    s = s - ONE;
    if (s[CNT_W+1])           s = '0;
    return s[CNT_W-1:0];
  endfunction

  // x0 has no counter; treat its lookup as permanently zero.
  always_comb begin
    cnt_iw = (bus.issue_waddr == 5'd0) ? '0 : cnt[bus.issue_waddr];
    cnt_r1 = (bus.raddr1 == 5'd0)      ? '0 : cnt[bus.raddr1];
    cnt_r2 = (bus.raddr2 == 5'd0)      ? '0 : cnt[bus.raddr2];
  end

  assign bus.issue_ready = !(bus.issue_we && bus.issue_waddr != 5'd0 &&
                             cnt_iw == CNT_MAX);
  assign issue_fire = bus.issue_valid && bus.issue_we && bus.issue_ready &&
                      bus.issue_waddr != 5'd0;

  always_comb begin
    inc_hit = '0;
    wb_hit  = '0;
    cn_hit  = '0;
    for (int i = 1; i < 32; i++) begin
      inc_hit[i] = issue_fire    && (bus.issue_waddr  == 5'(i));
      wb_hit[i]  = bus.rf_we     && (bus.rf_waddr     == 5'(i));
      cn_hit[i]  = bus.cancel_we && (bus.cancel_waddr == 5'(i));
    end
  end

  // Read ports
  always_comb begin
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    bus.busy1  = 1'b0;
    bus.busy2  = 1'b0;
    if (bus.raddr1 != 5'd0) begin
      bus.rdata1 = regs[bus.raddr1];
      bus.busy1  = (cnt_r1 != '0);
`ifdef REGFILE_BYPASS_EN
      if (bus.rf_we && bus.rf_waddr == bus.raddr1) begin
        bus.rdata1 = bus.rf_wdata;
        // The lone pending writer is retiring right now, unless a cancel
        // also hits this register (then the count was not ours alone).
        if (cnt_r1 == CNT_W'(1) &&
            !(bus.cancel_we && bus.cancel_waddr == bus.raddr1))
          bus.busy1 = 1'b0;
      end
`endif
    end
    if (bus.raddr2 != 5'd0) begin
      bus.rdata2 = regs[bus.raddr2];
      bus.busy2  = (cnt_r2 != '0);
`ifdef REGFILE_BYPASS_EN
      if (bus.rf_we && bus.rf_waddr == bus.raddr2) begin
        bus.rdata2 = bus.rf_wdata;
        if (cnt_r2 == CNT_W'(1) &&
            !(bus.cancel_we && bus.cancel_waddr == bus.raddr2))
          bus.busy2 = 1'b0;
      end
`endif
    end
  end

  // State update; reset wins over every same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (bus.rf_we && bus.rf_waddr != 5'd0)
        regs[bus.rf_waddr] <= bus.rf_wdata;
      for (int i = 1; i < 32; i++)
        cnt[i] <= cnt_sat(cnt[i], inc_hit[i], wb_hit[i], cn_hit[i]);
    end
  end

endmodule
